fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the RISC-V core, replacing the fixed single-register fetch stage.
- Holds a word-addressed PC and issues reads to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned instructions with their PCs in a flush-able FIFO.
- Presents them to EX over a valid/ready handshake.
- Accepts redirects (branch/jal/jalr) that flush all buffered and in-flight fetches.

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/fetch_fifo.sv | 83 ++++++++
 rtl/fetch_unit.sv | 153 +++++++++++++++
 tb/tb_fetch_unit.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, entry type and helpers for the fetch front end.
//   PC_W_DEF / INST_W_DEF : default PC (word address) and instruction widths.
//   fetch_entry_t         : default {pc, inst} prefetch buffer entry.
//   pc_inc                : PC increment wrapping modulo 2^width.
//   sat_add               : 32-bit saturating add for performance counters.
package fetch_pkg;

  localparam int unsigned PC_W_DEF   = 12;
  localparam int unsigned INST_W_DEF = 32;

  typedef struct packed {
    logic [PC_W_DEF-1:0]   pc;
    logic [INST_W_DEF-1:0] inst;
  } fetch_entry_t;

  // Caller truncates the result back to its own PC width.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc, input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (pc + 32'd1) & mask;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries with single-cycle flush.
//   clk, rst     : clock, synchronous active-high reset.
//   push_i/push_data_i : write an entry at the edge.
//   pop_i        : drop the head entry at the edge.
//   flush_i      : empty the FIFO; overrides push and pop in the same cycle.
//   full_o/empty_o/count_o : registered status and occupancy.
//   head_o       : head entry, straight from storage (stable until popped).
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  entry_t                   push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output entry_t                   head_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_en, pop_en;

  assign push_en = push_i && !flush_i;
  assign pop_en  = pop_i && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push_en, pop_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_i && !flush_i && full_o && !pop_i));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop_i && !flush_i && empty_o));

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end.
//   Holds a word PC, issues reads to a 1-cycle-latency synchronous instruction
//   memory, buffers {pc, inst} in a flushable prefetch FIFO and presents the
//   head to EX over valid/ready. A redirect flushes buffered and in-flight work.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset.
//   imem_en/imem_addr         : read strobe and word address (combinational).
//   imem_rdata                : read data, valid the cycle after imem_en.
//   redirect_valid/redirect_pc: PC change request from EX (highest priority).
//   inst_valid/inst_ready     : head handshake; inst_data/inst_pc are the head.
//   fifo_count                : prefetch buffer occupancy.
//   perf_fetched/flushed/stall: saturating counters when FETCH_PERF_EN is
//                               defined, otherwise tied to zero.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W       = PC_W_DEF,
  parameter int unsigned INST_W     = INST_W_DEF,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          imem_en,
  output logic [PC_W-1:0]               imem_addr,
  input  logic [INST_W-1:0]             imem_rdata,
  input  logic                          redirect_valid,
  input  logic [PC_W-1:0]               redirect_pc,
  output logic                          inst_valid,
  input  logic                          inst_ready,
  output logic [INST_W-1:0]             inst_data,
  output logic [PC_W-1:0]               inst_pc,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [31:0]                   perf_fetched,
  output logic [31:0]                   perf_flushed,
  output logic [31:0]                   perf_stall
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic [PC_W-1:0] pc_q, pc_d;
  logic            inflight_q, inflight_d;
  logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;

  logic            issue, push, pop;
  logic [CW:0]     occupancy;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_cnt;
  entry_t          push_entry, head;

  always_comb begin
    // Credit counts the in-flight read so its return always has a slot;
    // a same-cycle pop is deliberately not credited.
    occupancy = (CW + 1)'(fifo_cnt) + (CW + 1)'(inflight_q);
    issue     = !rst && !redirect_valid && (occupancy < (CW + 1)'(FIFO_DEPTH));
    push      = inflight_q && !redirect_valid;
    pop       = !fifo_empty && inst_ready && !redirect_valid;

    push_entry.pc   = inflight_pc_q;
    push_entry.inst = imem_rdata;

    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (issue) begin
      pc_d          = PC_W'(pc_inc(32'(pc_q), PC_W));
      inflight_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= PC_W'(RESET_PC);
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_cnt),
    .head_o      (head)
  );

  assign imem_en    = issue;
  assign imem_addr  = pc_q;
  assign inst_valid = !fifo_empty;
  assign inst_data  = head.inst;
  assign inst_pc    = head.pc;
  assign fifo_count = fifo_cnt;

  // Credit invariant: a full buffer never has a read outstanding.
  a_credit: assert property (@(posedge clk) disable iff (rst) !(fifo_full && inflight_q));

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushed_q, perf_flushed_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_flushed_d = perf_flushed_q;
    perf_stall_d   = perf_stall_q;
    if (push) perf_fetched_d = sat_add(perf_fetched_q, 32'd1);
    if (redirect_valid) begin
      perf_flushed_d = sat_add(perf_flushed_q, 32'(fifo_cnt) + 32'(inflight_q));
    end
    if (inst_valid && !inst_ready) perf_stall_d = sat_add(perf_stall_q, 32'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
  assign perf_stall   = perf_stall_q;
`else
  assign perf_fetched = 32'd0;
  assign perf_flushed = 32'd0;
  assign perf_stall   = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a default instance (PC_W 12, depth 4) and a
// PC_W 4 instance for wrap-around. Memory word k holds 0x1000 + k.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_ready;

  logic        imem_en;
  logic [11:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid;
  logic [11:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [11:0] inst_pc;
  logic [2:0]  fifo_count;
  logic [31:0] perf_fetched, perf_flushed, perf_stall;

  logic        imem_en2;
  logic [3:0]  imem_addr2;
  logic [31:0] imem_rdata2 = '0;
  logic        redirect_valid2;
  logic [3:0]  redirect_pc2;
  logic        inst_valid2;
  logic [31:0] inst_data2;
  logic [3:0]  inst_pc2;
  logic [2:0]  fifo_count2;
  logic [31:0] perf_fetched2, perf_flushed2, perf_stall2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk            (clk),
    .rst            (rst),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .fifo_count     (fifo_count),
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed),
    .perf_stall     (perf_stall)
  );

  fetch_unit #(.PC_W(4)) u_dut_w4 (
    .clk            (clk),
    .rst            (rst),
    .imem_en        (imem_en2),
    .imem_addr      (imem_addr2),
    .imem_rdata     (imem_rdata2),
    .redirect_valid (redirect_valid2),
    .redirect_pc    (redirect_pc2),
    .inst_valid     (inst_valid2),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data2),
    .inst_pc        (inst_pc2),
    .fifo_count     (fifo_count2),
    .perf_fetched   (perf_fetched2),
    .perf_flushed   (perf_flushed2),
    .perf_stall     (perf_stall2)
  );

  // Synchronous instruction memories, one cycle read latency.
  always @(posedge clk) begin
    if (imem_en)  imem_rdata  <= 32'h1000 + 32'(imem_addr);
    if (imem_en2) imem_rdata2 <= 32'h1000 + 32'(imem_addr2);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    redirect_valid2 = 1'b0;
    redirect_pc2 = '0;
    cyc();
    cyc();
  endtask

  task automatic test_reset();
    logic [31:0] exp_perf;
    inst_ready = 1'b1;
    apply_reset();
    #1;
    tests++;
    if (imem_en !== 1'b0 || inst_valid !== 1'b0 || fifo_count !== 3'd0) begin
      fails++;
      $display("FAIL reset_outputs: en=%b valid=%b count=%0d, want 0 0 0",
               imem_en, inst_valid, fifo_count);
    end
    exp_perf = 32'd0;
    tests++;
    if (perf_fetched !== exp_perf || perf_flushed !== exp_perf || perf_stall !== exp_perf) begin
      fails++;
      $display("FAIL reset_perf: %0d %0d %0d, want 0", perf_fetched, perf_flushed, perf_stall);
    end
    // Release: address k in cycle k, head pc k-2 in cycle k.
    for (int k = 0; k < 8; k++) begin
      logic [11:0] exp_pc;
      cyc();
      rst = 1'b0;
      #1;
      tests++;
      if (imem_en !== 1'b1 || imem_addr !== 12'(k)) begin
        fails++;
        $display("FAIL stream_addr c%0d: en=%b addr=%0h, want 1 %0h", k, imem_en, imem_addr, k);
      end
      tests++;
      if (inst_valid !== (k >= 2)) begin
        fails++;
        $display("FAIL stream_valid c%0d: got %b want %b", k, inst_valid, k >= 2);
      end
      if (k >= 2) begin
        exp_pc = 12'(k - 2);
        tests++;
        if (inst_pc !== exp_pc || inst_data !== 32'h1000 + 32'(exp_pc) || fifo_count !== 3'd1)
        begin
          fails++;
          $display("FAIL stream_head c%0d: pc=%0h data=%0h cnt=%0d, want %0h %0h 1",
                   k, inst_pc, inst_data, fifo_count, exp_pc, 32'h1000 + 32'(exp_pc));
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_stall, exp_fetch;
    inst_ready = 1'b0;
    apply_reset();
    for (int c = 0; c < 20; c++) begin
      cyc();
      rst = 1'b0;
      inst_ready = (c >= 12);
      #1;
      if (c >= 2 && c < 12) begin
        tests++;
        if (inst_valid !== 1'b1 || inst_pc !== 12'h000 || inst_data !== 32'h1000) begin
          fails++;
          $display("FAIL stall_head c%0d: valid=%b pc=%0h data=%0h, want 1 0 1000",
                   c, inst_valid, inst_pc, inst_data);
        end
      end
      if (c == 11) begin
        tests++;
        if (fifo_count !== 3'd4 || imem_en !== 1'b0) begin
          fails++;
          $display("FAIL stall_full: count=%0d en=%b, want 4 0", fifo_count, imem_en);
        end
      end
      if (c >= 12) begin
        tests++;
        if (inst_valid !== 1'b1 || inst_pc !== 12'(c - 12)) begin
          fails++;
          $display("FAIL drain c%0d: valid=%b pc=%0h, want 1 %0h", c, inst_valid, inst_pc, c - 12);
        end
      end
      if (c == 12) begin
`ifdef FETCH_PERF_EN
        exp_stall = 32'd10;
        exp_fetch = 32'd4;
`else
        exp_stall = 32'd0;
        exp_fetch = 32'd0;
`endif
        tests++;
        if (perf_stall !== exp_stall || perf_fetched !== exp_fetch) begin
          fails++;
          $display("FAIL stall_perf: stall=%0d fetched=%0d, want %0d %0d",
                   perf_stall, perf_fetched, exp_stall, exp_fetch);
        end
      end
    end
  endtask

  // Redirect with 3 buffered entries and pc 3 in flight (cycle 4 of a stall).
  task automatic test_redirect();
    logic [31:0] exp_flush;
    inst_ready = 1'b0;
    apply_reset();
    for (int c = 0; c < 9; c++) begin
      cyc();
      rst = 1'b0;
      redirect_valid = (c == 4);
      redirect_pc = 12'h040;
      #1;
      if (c == 4) begin
        tests++;
        if (fifo_count !== 3'd3 || imem_en !== 1'b0) begin
          fails++;
          $display("FAIL redir_pre: count=%0d en=%b, want 3 0", fifo_count, imem_en);
        end
      end
      if (c == 5) begin
        tests++;
        if (inst_valid !== 1'b0 || fifo_count !== 3'd0 || imem_addr !== 12'h040 || !imem_en)
        begin
          fails++;
          $display("FAIL redir_flush: valid=%b count=%0d addr=%0h en=%b, want 0 0 40 1",
                   inst_valid, fifo_count, imem_addr, imem_en);
        end
`ifdef FETCH_PERF_EN
        exp_flush = 32'd4;
`else
        exp_flush = 32'd0;
`endif
        tests++;
        if (perf_flushed !== exp_flush) begin
          fails++;
          $display("FAIL redir_perf: flushed=%0d, want %0d", perf_flushed, exp_flush);
        end
      end
      if (c == 6) begin
        tests++;
        if (inst_valid !== 1'b0) begin
          fails++;
          $display("FAIL redir_gap: valid=%b, want 0", inst_valid);
        end
      end
      if (c == 7) begin
        tests++;
        if (inst_valid !== 1'b1 || inst_pc !== 12'h040 || inst_data !== 32'h1040) begin
          fails++;
          $display("FAIL redir_first: valid=%b pc=%0h data=%0h, want 1 40 1040",
                   inst_valid, inst_pc, inst_data);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_pc;
    int j;
    inst_ready = 1'b1;
    apply_reset();
    for (int c = 0; c < 11; c++) begin
      cyc();
      rst = 1'b0;
      redirect_valid2 = (c == 3);
      redirect_pc2 = 4'hE;
      #1;
      j = c - 3;
      if (j >= 1 && j <= 4) begin
        exp_pc = 4'(14 + j - 1);
        tests++;
        if (imem_en2 !== 1'b1 || imem_addr2 !== exp_pc) begin
          fails++;
          $display("FAIL wrap_addr j%0d: en=%b addr=%0h, want 1 %0h", j, imem_en2, imem_addr2,
                   exp_pc);
        end
      end
      if (j >= 3 && j <= 6) begin
        exp_pc = 4'(14 + j - 3);
        tests++;
        if (inst_valid2 !== 1'b1 || inst_pc2 !== exp_pc || inst_data2 !== 32'h1000 + 32'(exp_pc))
        begin
          fails++;
          $display("FAIL wrap_head j%0d: valid=%b pc=%0h data=%0h, want 1 %0h", j, inst_valid2,
                   inst_pc2, inst_data2, exp_pc);
        end
      end
    end
    redirect_valid2 = 1'b0;
  endtask

  // Redirect collides with a pop (ready high) and a push (pc 3 returning).
  task automatic test_redirect_collide();
    logic [31:0] exp_fetch;
    inst_ready = 1'b0;
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      cyc();
      rst = 1'b0;
      inst_ready = (c >= 4);
      redirect_valid = (c == 4);
      redirect_pc = 12'h123;
      #1;
      if (c == 4) begin
        tests++;
        if (inst_valid !== 1'b1 || fifo_count !== 3'd3) begin
          fails++;
          $display("FAIL coll_pre: valid=%b count=%0d, want 1 3", inst_valid, fifo_count);
        end
      end
      if (c == 5) begin
        tests++;
        if (inst_valid !== 1'b0 || fifo_count !== 3'd0 || imem_addr !== 12'h123) begin
          fails++;
          $display("FAIL coll_flush: valid=%b count=%0d addr=%0h, want 0 0 123",
                   inst_valid, fifo_count, imem_addr);
        end
`ifdef FETCH_PERF_EN
        exp_fetch = 32'd3;
`else
        exp_fetch = 32'd0;
`endif
        tests++;
        if (perf_fetched !== exp_fetch) begin
          fails++;
          $display("FAIL coll_nopush: fetched=%0d, want %0d", perf_fetched, exp_fetch);
        end
      end
      if (c == 7) begin
        tests++;
        if (inst_valid !== 1'b1 || inst_pc !== 12'h123 || inst_data !== 32'h1123) begin
          fails++;
          $display("FAIL coll_first: valid=%b pc=%0h data=%0h, want 1 123 1123",
                   inst_valid, inst_pc, inst_data);
        end
      end
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    inst_ready = 1'b1;
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      cyc();
      rst = (c == 5 || c == 6);
      #1;
      if (c == 4) begin
        tests++;
        if (inst_valid !== 1'b1 || inst_pc !== 12'h002) begin
          fails++;
          $display("FAIL mid_pre: valid=%b pc=%0h, want 1 2", inst_valid, inst_pc);
        end
      end
      if (c == 5) begin
        tests++;
        if (imem_en !== 1'b0) begin
          fails++;
          $display("FAIL mid_en_in_rst: en=%b, want 0", imem_en);
        end
      end
      if (c == 6) begin
        tests++;
        if (inst_valid !== 1'b0 || fifo_count !== 3'd0 || imem_en !== 1'b0 ||
            perf_fetched !== 32'd0 || perf_stall !== 32'd0 || perf_flushed !== 32'd0) begin
          fails++;
          $display("FAIL mid_reset_state: valid=%b count=%0d en=%b fetched=%0d, want 0 0 0 0",
                   inst_valid, fifo_count, imem_en, perf_fetched);
        end
      end
      if (c == 7 || c == 8) begin
        tests++;
        if (inst_valid !== 1'b0 || fifo_count !== 3'd0 || imem_addr !== 12'(c - 7)) begin
          fails++;
          $display("FAIL mid_restart c%0d: valid=%b count=%0d addr=%0h, want 0 0 %0h",
                   c, inst_valid, fifo_count, imem_addr, c - 7);
        end
      end
      if (c == 9) begin
        tests++;
        if (inst_valid !== 1'b1 || inst_pc !== 12'h000 || inst_data !== 32'h1000) begin
          fails++;
          $display("FAIL mid_first: valid=%b pc=%0h data=%0h, want 1 0 1000",
                   inst_valid, inst_pc, inst_data);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    redirect_valid2 = 1'b0;
    redirect_pc2 = '0;
    test_reset();
    test_stall();
    test_redirect();
    test_wrap();
    test_redirect_collide();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
